muldiv_unit: RTL and testbench

- Iterative RV32M/RV64M multiply/divide execute unit. It sits beside the single-cycle ALU in the execute stage and handles instructions with opcode OP and funct7=0000001.
- Accepts one operation at a time over a valid/ready handshake, computes over multiple cycles and holds the result until the writeback side takes it.
- Generalises the combinational compute path in three ways: parametrised width, selectable bits-per-cycle throughput, and explicit flush and backpressure.

---
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M/RV64M multiply/divide unit with valid/ready I/O.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd
);

  localparam int c_iters = XLEN / BITS_PER_CYCLE;
  localparam int c_cnt_w = $clog2(c_iters) + 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_iters - 1);
  localparam logic [XLEN-1:0]    c_min  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_count;
  logic [XLEN-1:0]      r_hi;
  logic [XLEN-1:0]      r_lo;
  logic [XLEN-1:0]      r_opb;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_sel_hi;
  logic                 r_is_rem;
  logic [4:0]           r_rd;

  // ---------------- acceptance decode ----------------
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_special;

  assign in_ready   = (r_state == S_IDLE) && !flush;
  assign w_is_div   = in_funct3[2];
  assign w_a_signed = w_is_div ? !in_funct3[0] : (in_funct3[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? !in_funct3[0] : !in_funct3[1];
  assign w_a_neg    = w_a_signed & in_rs1[XLEN-1];
  assign w_b_neg    = w_b_signed & in_rs2[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~in_rs1 + XLEN'(1)) : in_rs1;
  assign w_b_mag    = w_b_neg ? (~in_rs2 + XLEN'(1)) : in_rs2;
  assign w_div0     = w_is_div && (in_rs2 == '0);
  assign w_ovf      = w_is_div && !in_funct3[0] && (in_rs1 == c_min) && (&in_rs2);
  assign w_special  = w_div0 ? (in_funct3[1] ? in_rs1 : '1)
                             : (in_funct3[1] ? '0 : in_rs1);

  // ---------------- shift-add step: {hi,lo} holds partial product / multiplier
  logic [XLEN+BITS_PER_CYCLE-1:0] w_mul_sum;
  logic [XLEN-1:0]                w_mul_hi;
  logic [XLEN-1:0]                w_mul_lo;

  always_comb begin
    w_mul_sum = {{BITS_PER_CYCLE{1'b0}}, r_hi};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_lo[i])
        w_mul_sum = w_mul_sum + ({{BITS_PER_CYCLE{1'b0}}, r_opb} << i);
    end
  end

  assign w_mul_hi = w_mul_sum[XLEN+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
  assign w_mul_lo = {w_mul_sum[BITS_PER_CYCLE-1:0], r_lo[XLEN-1:BITS_PER_CYCLE]};

  // ---------------- restoring division step: hi = remainder, lo = dividend/quotient
  logic [XLEN:0]   w_rem_v;
  logic [XLEN-1:0] w_quo_v;

  always_comb begin
    w_rem_v = {1'b0, r_hi};
    w_quo_v = r_lo;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_rem_v = {w_rem_v[XLEN-1:0], w_quo_v[XLEN-1]};
      w_quo_v = {w_quo_v[XLEN-2:0], 1'b0};
      if (w_rem_v >= {1'b0, r_opb}) begin
        w_rem_v    = w_rem_v - {1'b0, r_opb};
        w_quo_v[0] = 1'b1;
      end
    end
  end

  // ---------------- result fix-up on the final iteration
  logic [XLEN-1:0]   w_hi_next;
  logic [XLEN-1:0]   w_lo_next;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_final;

  assign w_hi_next  = (r_state == S_MUL) ? w_mul_hi : w_rem_v[XLEN-1:0];
  assign w_lo_next  = (r_state == S_MUL) ? w_mul_lo : w_quo_v;
  assign w_prod     = {w_hi_next, w_lo_next};
  assign w_prod_fix = r_neg_q ? (~w_prod + (2*XLEN)'(1)) : w_prod;
  assign w_quo_fix  = r_neg_q ? (~w_lo_next + XLEN'(1)) : w_lo_next;
  assign w_rem_fix  = r_neg_r ? (~w_hi_next + XLEN'(1)) : w_hi_next;
  assign w_final    = (r_state == S_MUL)
                    ? (r_sel_hi ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0])
                    : (r_is_rem ? w_rem_fix : w_quo_fix);

  // ---------------- control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_opb      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_sel_hi   <= 1'b0;
      r_is_rem   <= 1'b0;
      r_rd       <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
    end else if (flush) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_hi     <= '0;
            r_lo     <= w_a_mag;
            r_opb    <= w_b_mag;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_sel_hi <= (in_funct3[1:0] != 2'b00);
            r_is_rem <= in_funct3[1];
            r_rd     <= in_rd;
            r_count  <= '0;
            if (w_div0 || w_ovf) begin
              out_valid  <= 1'b1;
              out_result <= w_special;
              out_rd     <= in_rd;
              r_state    <= S_DONE;
            end else begin
              r_state <= w_is_div ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          r_hi    <= w_hi_next;
          r_lo    <= w_lo_next;
          r_count <= r_count + c_cnt_w'(1);
          if (r_count == c_last) begin
            r_count    <= '0;
            out_valid  <= 1'b1;
            out_result <= w_final;
            out_rd     <= r_rd;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench driving a 1-bit and a 4-bit-per-cycle unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1, in_rs2;
  logic [4:0]  in_rd;
  logic        rdy1, ov1, rdy4, ov4;
  logic [31:0] res1, res4;
  logic [4:0]  rd1, rd4;
  int          n_cmp  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(ov1), .out_ready(out_ready), .out_result(res1), .out_rd(rd1));

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy4),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(ov4), .out_ready(out_ready), .out_result(res4), .out_rd(rd4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic accept(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    @(negedge clk);
    check("in_ready_before_accept", {30'b0, rdy1, rdy4}, 32'd3);
    in_valid  = 1'b1;
    in_funct3 = f3;
    in_rs1    = a;
    in_rs2    = b;
    in_rd     = rd;
    @(posedge clk); #1;
    // Scramble the inputs to confirm the unit works from latched copies.
    in_valid  = 1'b0;
    in_funct3 = 3'($urandom);
    in_rs1    = $urandom;
    in_rs2    = $urandom;
    in_rd     = 5'($urandom);
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int hold);
    logic [31:0] exp;
    logic [31:0] snap1, snap4;
    logic [4:0]  srd1, srd4;
    int          lat1, lat4, cyc;
    bit          special, rdy_bad, stable_bad;
    exp     = ref_model(f3, a, b);
    special = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    accept(f3, a, b, rd);
    lat1 = 0; lat4 = 0; cyc = 1; rdy_bad = 0;
    while (1) begin
      if (ov1 && lat1 == 0) lat1 = cyc;
      if (ov4 && lat4 == 0) lat4 = cyc;
      if (rdy1 || rdy4) rdy_bad = 1;
      if ((lat1 != 0 && lat4 != 0) || cyc >= 100) break;
      @(posedge clk); #1;
      cyc++;
    end
    check("latency_bpc1", 32'(lat1), special ? 32'd1 : 32'd33);
    check("latency_bpc4", 32'(lat4), special ? 32'd1 : 32'd9);
    snap1 = res1; snap4 = res4; srd1 = rd1; srd4 = rd4; stable_bad = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!ov1 || !ov4 || res1 !== snap1 || res4 !== snap4 || rd1 !== srd1 || rd4 !== srd4)
        stable_bad = 1;
      if (rdy1 || rdy4) rdy_bad = 1;
    end
    check("hold_stable", 32'(stable_bad), 32'd0);
    check("result_bpc1", res1, exp);
    check("result_bpc4", res4, exp);
    check("rd_bpc1", 32'(rd1), 32'(rd));
    check("rd_bpc4", 32'(rd4), 32'(rd));
    out_ready = 1'b1;
    #1;
    if (rdy1 || rdy4) rdy_bad = 1;
    check("in_ready_low_while_busy", 32'(rdy_bad), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_transfer", {30'b0, ov1, ov4}, 32'd0);
    check("in_ready_after_transfer", {30'b0, rdy1, rdy4}, 32'd3);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    bit          leak;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    #12;
    check("reset_out_valid", {30'b0, ov1, ov4}, 32'd0);
    check("reset_out_result", res1 | res4, 32'd0);
    check("reset_out_rd", 32'(rd1 | rd4), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", {30'b0, rdy1, rdy4}, 32'd3);

    // Directed cases
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 5);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 2);
    do_op(3'd5, 32'd100, 32'd7, 5'd7, 0);
    do_op(3'd7, 32'd100, 32'd7, 5'd8, 0);
    do_op(3'd5, 32'd5, 32'd0, 5'd9, 0);
    do_op(3'd6, 32'd5, 32'd0, 5'd10, 3);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);

    // Randomised operations, biased towards the corner operands
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'hFFFF_FFFF;
        3: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
        4: a = 32'h8000_0000;
        default: ;
      endcase
      do_op(f3, a, b, 5'($urandom), $urandom_range(0, 3));
    end

    // Flush during iteration 10
    accept(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("in_ready_low_during_flush", {30'b0, rdy1, rdy4}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush_out_valid", {30'b0, ov1, ov4}, 32'd0);
    check("flush_in_ready", {30'b0, rdy1, rdy4}, 32'd3);
    leak = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov1 || ov4) leak = 1;
    end
    check("flush_no_result", 32'(leak), 32'd0);
    do_op(3'd0, 32'd3, 32'd4, 5'd21, 0);

    // Reset during iteration 10
    accept(3'd1, 32'h7654_3210, 32'h0FED_CBA9, 5'd22);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_out_valid", {30'b0, ov1, ov4}, 32'd0);
    check("async_reset_out_result", res1 | res4, 32'd0);
    check("async_reset_in_ready", {30'b0, rdy1, rdy4}, 32'd3);
    @(negedge clk);
    reset = 1'b0;
    leak = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov1 || ov4) leak = 1;
    end
    check("reset_no_result", 32'(leak), 32'd0);
    do_op(3'd0, 32'd3, 32'd4, 5'd23, 0);

    // Flush in DONE together with out_ready drops the result
    accept(3'd5, 32'd5, 32'd0, 5'd24);
    check("special_done_valid", {30'b0, ov1, ov4}, 32'd3);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done_out_valid", {30'b0, ov1, ov4}, 32'd0);

    // Flush coinciding with a request does not accept it
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_funct3 = 3'd5; in_rs1 = 32'd9; in_rs2 = 32'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    leak = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ov1 || ov4 || !rdy1 || !rdy4) leak = 1;
    end
    check("flush_blocks_accept", 32'(leak), 32'd0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd25, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
